fifo_v2: RTL and testbench
==========================

FIFO_V2 -- requirements
Module: fifo_v2

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 512: entries; power of two, at least 4.
REQ-003 SHALL have parameter AF_LVL, default DEPTH-4: almost-full threshold.
REQ-004 SHALL have parameter AE_LVL, default 4: almost-empty threshold.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have these ports:
- push, input, 1 bit: write request.
- din, input, DW bits: write data.
- pop, input, 1 bit: read request.
- flush, input, 1 bit: synchronous clear of contents.
- err_clr, input, 1 bit: clears sticky error flags.
- dump, input, 1 bit: memory-dump trigger.
REQ-008 SHALL have these outputs:
- dout, output, DW bits: read data.
- dout_vld, output, 1 bit: dout holds a popped word.
- full, empty, almost_full, almost_empty: outputs, 1 bit each.
- level, output, $clog2(DEPTH)+1 bits: current occupancy.
- ovf, udf: outputs, 1 bit each, sticky overflow and underflow.

Function
REQ-009 SHALL accept a push when push=1 and (level<DEPTH, or a pop is accepted in the same cycle).
REQ-010 SHALL accept a pop when pop=1 and level>0; no fall-through: a pop with level=0 is rejected even if push=1 in the same cycle.
REQ-011 SHALL write din into the write-pointer entry on an accepted push, then increment the write pointer modulo DEPTH.
REQ-012 SHALL register the read-pointer entry into dout on an accepted pop, assert dout_vld for exactly the next cycle, and increment the read pointer modulo DEPTH; read latency is 1 cycle.
REQ-013 SHALL hold dout at its last value when no pop is accepted; dout_vld=0 in that case.
REQ-014 SHALL update level by: +1 on push only, -1 on pop only, unchanged on both or neither; level never leaves 0..DEPTH.
REQ-015 SHALL decode flags from registered level:
- full = (level==DEPTH)
- empty = (level==0)
- almost_full = (level>=AF_LVL)
- almost_empty = (level<=AE_LVL)
REQ-016 SHALL ignore a rejected push (memory unchanged) and set ovf; SHALL ignore a rejected pop and set udf.
REQ-017 SHALL clear ovf and udf on err_clr=1; a new error in the same cycle as err_clr takes priority and sets the flag.
REQ-018 SHALL, on flush=1, zero both pointers and level and drop any push or pop in that cycle without setting ovf or udf; dout keeps its value, and dout_vld=0 in the next cycle.

Reset
REQ-019 SHALL, while rst=0, asynchronously force:
- pointers=0, level=0, dout=0, dout_vld=0, ovf=0, udf=0
- therefore empty=1, almost_empty=1, full=0, almost_full=0
REQ-020 SHALL NOT reset memory contents; reset asserted mid-operation discards all queued data.

Configuration
REQ-021 SHALL, with FIFO_DUMP_EN defined, print "MEMDUMP:@@<time> " and then every "index:hexvalue, " pair for all DEPTH entries on each rising edge of dump.
REQ-022 SHALL, without FIFO_DUMP_EN, keep the dump port but ignore it, with no simulation output and no logic.

Structure
REQ-023 SHALL take from package fifo_v2_pkg:
- fifo_status_t, a packed struct of full/empty/almost_full/almost_empty/ovf/udf
- function lvl_w(depth), returning $clog2(depth)+1
REQ-024 SHALL place storage in sub-module fifo_v2_mem: DEPTH x DW, one synchronous write port, one synchronous read port.

Verification
REQ-025 Reset then 512 pushes of din=i (DEPTH=512) -> full=1 and level=512 after the last push; 513th push -> memory unchanged, ovf=1.
REQ-026 From full, 512 pops -> dout=0,1,...,511, each one cycle after its pop with dout_vld=1, then empty=1; one more pop -> udf=1, dout_vld=0.
REQ-027 Simultaneous push and pop at level=512 -> both accepted, level stays 512, ovf=0; same at level=0 -> pop rejected, udf=1, level=1.
REQ-028 Push 600 and pop 600 interleaved so the pointers wrap -> data order preserved; almost_full rises at level 508 and almost_empty falls at level 5.
REQ-029 flush at level 10 with push=1 -> level=0, ovf=0; rst=0 asserted mid-burst -> all outputs take their REQ-019 values immediately, without waiting for a clock edge.
REQ-030 err_clr with a concurrent rejected pop -> udf stays 1; dump=1 -> 512 entries printed only when FIFO_DUMP_EN is defined.

Source files
------------

// File: rtl/fifo_v2_pkg.sv
// rtl/fifo_v2_pkg.sv - shared types and helpers for the fifo_v2 queue
//
// Contents:
//   fifo_status_t : packed status flags decoded from the registered occupancy
//                   plus the two sticky error flags
//   lvl_w(depth)  : width of an occupancy counter able to hold 0..depth
package fifo_v2_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic ovf;
        logic udf;
    } fifo_status_t;

    // One extra bit over the address width so that "exactly DEPTH" is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_v2_mem.sv
// rtl/fifo_v2_mem.sv - DEPTH x DW storage with one sync write and one sync read port
//
// Ports:
//   clk      : clock, both ports update on its rising edge
//   rst      : asynchronous active-low reset, clears only the read-data register
//   wr_en    : write strobe, stores wr_data at wr_addr
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe, registers the entry at rd_addr into rd_data
//   rd_addr  : read address
//   rd_data  : registered read data, holds its value while rd_en is low
//   dump     : memory-dump trigger (only acted on when FIFO_DUMP_EN is defined)
//
// Build option FIFO_DUMP_EN: prints all entries on each rising edge of dump.
module fifo_v2_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          dump
);

    // Storage is deliberately left out of reset so it can map onto RAM macros.
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: when the queue is full and a push and pop land in the
    // same cycle, both ports address the same entry and the pop must see the
    // old word. The non-blocking read here samples the pre-write contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

`ifdef FIFO_DUMP_EN
    always @(posedge dump) begin
        $write("MEMDUMP:@@%0t ", $time);
        for (int i = 0; i < DEPTH; i++) begin
            $write("%0d:%h, ", i, mem[i]);
        end
        $write("\n");
    end
`else
    logic unused_dump;
    assign unused_dump = dump;
`endif

endmodule

// File: rtl/fifo_v2.sv
// rtl/fifo_v2.sv - synchronous FIFO with level, almost flags, sticky errors and flush
//
// Parameters:
//   DW     : data width
//   DEPTH  : number of entries, power of two, at least 4
//   AF_LVL : almost_full asserted while level >= AF_LVL
//   AE_LVL : almost_empty asserted while level <= AE_LVL
//
// Ports:
//   clk, rst         : clock and asynchronous active-low reset
//   push, din        : write request and data
//   pop              : read request; dout is valid one cycle later (dout_vld)
//   flush            : synchronous clear of pointers and level, drops same-cycle push/pop
//   err_clr          : clears ovf/udf; a same-cycle error wins
//   dump             : memory-dump trigger (see FIFO_DUMP_EN in fifo_v2_mem)
//   dout, dout_vld   : read data, and a one-cycle flag for each accepted pop
//   full, empty, almost_full, almost_empty : decoded from the registered level
//   level            : current occupancy, 0..DEPTH
//   ovf, udf         : sticky overflow (rejected push) and underflow (rejected pop)
//
// Build option FIFO_DUMP_EN: enables the simulation memory dump on dump.
module fifo_v2
    import fifo_v2_pkg::*;
#(
    parameter int DW     = 32,
    parameter int DEPTH  = 512,
    parameter int AF_LVL = DEPTH - 4,
    parameter int AE_LVL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     err_clr,
    input  logic                     dump,
    output logic [DW-1:0]            dout,
    output logic                     dout_vld,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [lvl_w(DEPTH)-1:0]  level,
    output logic                     ovf,
    output logic                     udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_LVL);
    localparam logic [LW-1:0] LVL_AE   = LW'(AE_LVL);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          vld_q;
    logic          ovf_q;
    logic          udf_q;

    logic          push_ok;
    logic          pop_ok;
    logic          ovf_set;
    logic          udf_set;
    fifo_status_t  status;

    // Acceptance. Pop is decided first because a pop at full frees the slot
    // the same-cycle push needs. There is no fall-through: at level 0 the pop
    // is refused even if a push arrives together with it. Flush suppresses
    // both requests and the errors they would otherwise raise.
    always_comb begin
        pop_ok  = 1'b0;
        push_ok = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (!flush) begin
            pop_ok  = pop  && (level_q != '0);
            push_ok = push && ((level_q != LVL_FULL) || pop_ok);
            ovf_set = push && !push_ok;
            udf_set = pop  && !pop_ok;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            vld_q <= pop_ok;
            // A fresh error outranks a concurrent clear.
            ovf_q <= ovf_set || (ovf_q && !err_clr);
            udf_q <= udf_set || (udf_q && !err_clr);
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
            end else begin
                // Pointers wrap naturally since DEPTH is a power of two.
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push_ok, pop_ok})
                    2'b10:   level_q <= level_q + 1'b1;
                    2'b01:   level_q <= level_q - 1'b1;
                    default: level_q <= level_q;
                endcase
            end
        end
    end

    always_comb begin
        status              = '0;
        status.full         = (level_q == LVL_FULL);
        status.empty        = (level_q == '0);
        status.almost_full  = (level_q >= LVL_AF);
        status.almost_empty = (level_q <= LVL_AE);
        status.ovf          = ovf_q;
        status.udf          = udf_q;
    end

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign ovf          = status.ovf;
    assign udf          = status.udf;
    assign level        = level_q;
    assign dout_vld     = vld_q;

    fifo_v2_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (dout),
        .dump    (dump)
    );

endmodule

// File: tb/tb_fifo_v2.sv
// tb/tb_fifo_v2.sv - scoreboard bench for fifo_v2 against a queue reference model
module tb_fifo_v2;

    localparam int DW    = 32;
    localparam int DEPTH = 512;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] din = '0;
    logic          pop = 1'b0;
    logic          flush = 1'b0;
    logic          err_clr = 1'b0;
    logic          dump = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [LW-1:0] level;
    logic          ovf;
    logic          udf;

    fifo_v2 #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .din          (din),
        .pop          (pop),
        .flush        (flush),
        .err_clr      (err_clr),
        .dump         (dump),
        .dout         (dout),
        .dout_vld     (dout_vld),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .ovf          (ovf),
        .udf          (udf)
    );

    always #5 clk = ~clk;

    // Reference model: the queue contents, sticky errors and last popped word.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf;
    bit            m_udf;
    logic [DW-1:0] m_dout;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = '0;
    endtask

    // {level, full, empty, almost_full, almost_empty, ovf, udf}
    task automatic check_status(input string name);
        int n;
        logic [LW+5:0] exp_v;
        n = mq.size();
        exp_v = {LW'(n), n == DEPTH, n == 0, n >= DEPTH - 4, n <= 4, m_ovf, m_udf};
        check(name, 64'({level, full, empty, almost_full, almost_empty, ovf, udf}), 64'(exp_v));
        check({name, "_dout"}, 64'(dout), 64'(m_dout));
    endtask

    // One clock of stimulus: model decides acceptance from the FIFO rules,
    // the monitor later matches each popped word as dout_vld presents it.
    task automatic step(input bit p, input logic [DW-1:0] d, input bit q, input bit f, input bit ec);
        bit            pa;
        bit            qa;
        logic [DW-1:0] popped;
        @(negedge clk);
        check("dout_vld_missing", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        push = p; din = d; pop = q; flush = f; err_clr = ec;
        pa = 1'b0;
        qa = 1'b0;
        popped = '0;
        if (!f) begin
            qa = q && (mq.size() > 0);
            pa = p && ((mq.size() < DEPTH) || qa);
        end
        if (qa) popped = mq.pop_front();
        if (pa) mq.push_back(d);
        if (f) mq.delete();
        m_ovf = (p && !f && !pa) || (m_ovf && !ec);
        m_udf = (q && !f && !qa) || (m_udf && !ec);
        if (qa) m_dout = popped;
        @(posedge clk);
        #1;
        if (qa) exp_q.push_back(popped);
        push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
        check_status("status");
    endtask

    // Monitor: consumes one expected word per dout_vld pulse.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (dout_vld) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_dout_vld: got dout_vld=1 dout=%h expected dout_vld=0 at %0t", dout, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("dout_order", 64'(dout), 64'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_status("reset");
        check("reset_vld", 64'(dout_vld), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fill completely, then one overflowing push that must not land.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        check("fill_full", 64'({full, level}), 64'({1'b1, LW'(DEPTH)}));
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        check("ovf_after_513", 64'(ovf), 64'd1);

        // Push+pop at full: both accepted, level unchanged.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0);
        check("pushpop_full", 64'({ovf, level}), 64'({1'b0, LW'(DEPTH)}));

        // Drain everything, then an underflowing pop.
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("drained_empty", 64'(empty), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("udf_after_pop", 64'({udf, dout_vld}), 64'({1'b1, 1'b0}));

        // Clear racing with a new underflow keeps udf set; a plain clear drops it.
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("udf_clr_race", 64'(udf), 64'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Push+pop at empty: no fall-through.
        step(1'b1, 32'hABCD, 1'b1, 1'b0, 1'b0);
        check("pushpop_empty", 64'({udf, level}), 64'({1'b1, LW'(1)}));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Randomised traffic, first biased up then down so pointers wrap and
        // both almost thresholds and both limits are crossed repeatedly.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                bit p;
                bit q;
                p = (ph % 2 == 0) ? ($urandom_range(3, 0) != 0) : ($urandom_range(1, 0) != 0);
                q = (ph % 2 == 0) ? ($urandom_range(1, 0) != 0) : ($urandom_range(3, 0) != 0);
                step(p, $urandom, q, ($urandom_range(255, 0) == 0), ($urandom_range(15, 0) == 0));
            end
        end

        // Flush at level 10 with a concurrent push.
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h5555, 1'b0, 1'b1, 1'b0);
        check("flush_lvl", 64'({ovf, level}), 64'({1'b0, LW'(0)}));

        // Asynchronous reset in the middle of a burst, with flags and dout live.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, $urandom | 32'h1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h7777, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_status("async_reset");
        check("async_reset_vld", 64'(dout_vld), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, ($urandom_range(1, 0) != 0), 1'b0, 1'b0);

        @(negedge clk);
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
